// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN finishes on the first differing chunk.
module seq_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_unsigned_op,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_a_lt_b,
    output logic             o_a_eq_b,
    output logic             o_a_gt_b
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;
    logic             flag_lt_q, flag_lt_d;
    logic             flag_eq_q, flag_eq_d;
    logic             flag_gt_q, flag_gt_d;

    logic [CHUNK-1:0] ca, cb;
    logic             differ;
    logic             dec_now;
    logic             lt_now;
    logic             last;

    always_comb begin
        ca = '0;
        cb = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign differ  = (ca != cb);
    assign dec_now = decided_q | differ;
    assign lt_now  = decided_q ? lt_q : (ca < cb);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        flag_lt_d = flag_lt_q;
        flag_eq_d = flag_eq_q;
        flag_gt_d = flag_gt_q;
        last      = 1'b0;

        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        // Signed mode flips the sign bits once at capture, so every
                        // chunk compare afterwards is a plain unsigned compare.
                        a_d            = i_a;
                        b_d            = i_b;
                        a_d[WIDTH-1]   = i_a[WIDTH-1] ^ ~i_unsigned_op;
                        b_d[WIDTH-1]   = i_b[WIDTH-1] ^ ~i_unsigned_op;
                        k_d            = KW'(NCHUNK - 1);
                        decided_d      = 1'b0;
                        lt_d           = 1'b0;
                        state_d        = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    decided_d = dec_now;
                    lt_d      = lt_now;
                    k_d       = k_q - KW'(1);
                    last      = (k_q == '0);
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    last      = last | (~decided_q & differ);
`endif
                    if (last) begin
                        state_d   = ST_DONE;
                        flag_eq_d = ~dec_now;
                        flag_lt_d = dec_now & lt_now;
                        flag_gt_d = dec_now & ~lt_now;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            flag_lt_q <= 1'b0;
            flag_eq_q <= 1'b0;
            flag_gt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            flag_lt_q <= flag_lt_d;
            flag_eq_q <= flag_eq_d;
            flag_gt_q <= flag_gt_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_a_lt_b = flag_lt_q;
    assign o_a_eq_b = flag_eq_q;
    assign o_a_gt_b = flag_gt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Randomised bench for seq_comparator with a transaction-level reference model.
module tb_seq_comparator;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam int LAT_MSB = 1;
`else
    localparam int LAT_MSB = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_unsigned_op;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic             o_a_lt_b;
    logic             o_a_eq_b;
    logic             o_a_gt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_unsigned_op(i_unsigned_op),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_a_lt_b     (o_a_lt_b),
        .o_a_eq_b     (o_a_eq_b),
        .o_a_gt_b     (o_a_gt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {lt, eq, gt}
    function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic uns);
        if (a == b) return 3'b010;
        if (uns) return (a < b) ? 3'b100 : 3'b001;
        return ($signed(a) < $signed(b)) ? 3'b100 : 3'b001;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        logic [31:0] x;
        for (int k = NCHUNK - 1; k >= 0; k--) begin
            x = (a ^ b) >> (k * CHUNK);
            if (x[CHUNK-1:0] != '0) return NCHUNK - k;
        end
`endif
        return NCHUNK;
    endfunction

    // Reference model: result appears ref_lat edges after acceptance, held until handshake.
    logic       m_busy, m_have;
    int         m_left;
    logic [2:0] m_flags, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_have  <= 1'b0;
            m_left  <= 0;
            m_flags <= 3'b000;
            m_pend  <= 3'b000;
        end else if (i_flush) begin
            m_busy <= 1'b0;
            m_have <= 1'b0;
        end else if (m_have) begin
            if (i_ready) m_have <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_have  <= 1'b1;
                m_flags <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (i_valid) begin
            m_pend <= ref_cmp(i_a, i_b, i_unsigned_op);
            m_left <= ref_lat(i_a, i_b);
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_ready", o_ready, !(m_busy || m_have));
            check("mdl_valid", o_valid, m_have);
            check("mdl_flags", {o_a_lt_b, o_a_eq_b, o_a_gt_b}, m_flags);
        end
    end

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input int hold, input logic scramble,
                         input logic [2:0] exp_f, input int exp_lat);
        int cnt;
        logic [2:0] f0;
        i_a = a; i_b = b; i_unsigned_op = uns; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 64) begin
            if (scramble) begin
                i_a = $urandom; i_b = $urandom; i_unsigned_op = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_lat"}, cnt, exp_lat);
        if (!o_valid) return;
        f0 = {o_a_lt_b, o_a_eq_b, o_a_gt_b};
        check({name, "_flags"}, f0, exp_f);
        repeat (hold) begin
            i_valid = 1'($urandom_range(0, 1));
            i_a = $urandom; i_b = $urandom;
            @(posedge clk); #1;
            check({name, "_hold_ready"}, o_ready, 1'b0);
            check({name, "_hold_valid"}, o_valid, 1'b1);
            check({name, "_hold_flags"}, {o_a_lt_b, o_a_eq_b, o_a_gt_b}, exp_f);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({name, "_ready_after"}, o_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        uns;
        int          cnt;
        rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0;
        i_unsigned_op = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_flags", {o_a_lt_b, o_a_eq_b, o_a_gt_b}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("pin_ref_u_gt",  ref_cmp(32'hFFFF_FFFF, 32'h1, 1'b1), 3'b001);
        check("pin_ref_s_lt",  ref_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0), 3'b100);
        check("pin_ref_u_eq",  ref_cmp(32'h1234_5678, 32'h1234_5678, 1'b1), 3'b010);

        do_op("t1_u_ffff_1",  32'hFFFF_FFFF, 32'h1,         1'b1, 0, 1'b0, 3'b001, LAT_MSB);
        do_op("t2_s_ffff_1",  32'hFFFF_FFFF, 32'h1,         1'b0, 0, 1'b0, 3'b100, LAT_MSB);
        do_op("t2_s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 1'b0, 3'b100, LAT_MSB);
        do_op("t2_u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1'b0, 3'b001, LAT_MSB);
        do_op("t3_u_eq",      32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0, 3'b010, 4);
        do_op("t3_s_eq",      32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0, 3'b010, 4);
        do_op("t3_u_1_2",     32'h1,         32'h2,         1'b1, 0, 1'b0, 3'b100, 4);
        do_op("t4_hold5",     32'h0000_0010, 32'h0000_0020, 1'b1, 5, 1'b0, 3'b100, 4);
        do_op("t5_scramble",  32'h1122_3344, 32'h1122_3345, 1'b1, 2, 1'b1, 3'b100, 4);

        // Flush during BUSY
        i_a = 32'h100; i_b = 32'h101; i_unsigned_op = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("t6_flush_valid", o_valid, 1'b0);
        check("t6_flush_ready", o_ready, 1'b1);
        do_op("t6_after_flush", 32'h5, 32'h3, 1'b1, 0, 1'b0, 3'b001, 4);

        // Asynchronous reset during BUSY
        i_a = 32'h100; i_b = 32'h101; i_unsigned_op = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", o_ready, 1'b1);
        check("t6_rst_valid", o_valid, 1'b0);
        check("t6_rst_flags", {o_a_lt_b, o_a_eq_b, o_a_gt_b}, 3'b000);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("t6_after_rst", 32'h5, 32'h3, 1'b1, 0, 1'b0, 3'b001, 4);

        // Flush together with a request in IDLE must not accept it
        i_a = 32'h7; i_b = 32'h9; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_idle_ready", o_ready, 1'b1);

        // Flush while holding a result: o_valid drops, flags keep their values
        i_a = 32'h5; i_b = 32'h3; i_unsigned_op = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("flush_done_lat", cnt, 4);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_done_valid", o_valid, 1'b0);
        check("flush_done_ready", o_ready, 1'b1);
        check("flush_done_flags", {o_a_lt_b, o_a_eq_b, o_a_gt_b}, 3'b001);

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, 31));
                2:       b = $urandom;
                default: b = {a[31:8], 8'($urandom)};
            endcase
            uns = 1'($urandom_range(0, 1));
            do_op("rnd", a, b, uns, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  ref_cmp(a, b, uns), ref_lat(a, b));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
